data_controller: RTL and testbench
==================================

DATA_CONTROLLER -- requirements
Module: data_controller

Interface
REQ-001 SHALL have parameter DATA_W, default 128, meaning tile word width (4x4 tile x 8 bit).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning output tile FIFO entries.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 input_addr_1_i  in  8  block address of first tile.
REQ-006 input_addr_2_i  in  8  block address of second tile; 8'hFF = no second tile.
REQ-007 size_type_i  in  1  tile size type, passed through with the tile.
REQ-008 block_cnt_i  in  8  blocks per input channel.
REQ-009 current_id_i  in  4  input-channel index.
REQ-010 input_request_i  in  1  fetch request, one per cycle max.
REQ-011 memA_ren_o, memB_ren_o  out  1 each  read enables, ports A/B.
REQ-012 memA_addr_o, memB_addr_o  out  12 each  read addresses.
REQ-013 memA_rdata_i, memB_rdata_i  in  DATA_W each  read data, valid 1 cycle after ren.
REQ-014 tile_valid_o  out  1  FIFO head valid.
REQ-015 tile_ready_i  in  1  downstream accepts head.
REQ-016 tile1_o, tile2_o  out  DATA_W each  head tiles.
REQ-017 tile2_valid_o, tile_last_o, tile_size_type_o  out  1 each  head sideband.
REQ-018 tile_id_o  out  4  head channel index.
REQ-019 fifo_count_o  out  3  occupied entries, 0..FIFO_DEPTH.
REQ-020 overflow_o  out  1  sticky dropped-tile flag.
REQ-021 clear_i  in  1  clears overflow_o.

Function
REQ-022 Address: memX_addr_o = current_id_i*block_cnt_i + input_addr_X_i, computed in 12 bits, combinational from inputs; max 15*255+255 = 4080, no wrap.
REQ-023 memA_ren_o = input_request_i; memB_ren_o = input_request_i AND input_addr_2_i != 8'hFF; both combinational, same cycle as request.
REQ-024 Sideband (request, addr2-valid, current_id_i, size_type_i) SHALL register in a stage-1 register at the request edge.
REQ-025 In the cycle after a request, stage 1 SHALL push {memA_rdata_i, addr2-valid ? memB_rdata_i : 0, addr2-valid, last = !addr2-valid, id, size_type} into the FIFO.
REQ-026 Latency: request in cycle T with empty FIFO -> tile_valid_o high in T+2; back-to-back requests SHALL sustain one tile per cycle while tile_ready_i is high.
REQ-027 Pop occurs when tile_valid_o AND tile_ready_i; head outputs SHALL hold steady while tile_valid_o high and tile_ready_i low.
REQ-028 Push and pop in the same cycle SHALL both occur, including when full; count unchanged.
REQ-029 Push when full with no pop SHALL drop the entry, leave the FIFO unchanged, and set overflow_o on the next edge.
REQ-030 overflow_o SHALL stay high until clear_i; overflow event and clear_i in the same cycle -> overflow_o = 1.
REQ-031 When tile_valid_o = 0, tile1_o, tile2_o and sideband outputs SHALL be 0.
REQ-032 FIFO pointers SHALL wrap modulo FIFO_DEPTH; fifo_count_o SHALL equal pushes minus pops.

Reset
REQ-033 reset SHALL clear stage 1, FIFO pointers/count, overflow_o; outputs: tile_valid_o=0, fifo_count_o=0, overflow_o=0, all tile/sideband outputs 0.
REQ-034 reset mid-operation SHALL discard in-flight read data in the following cycle; no push from a pre-reset request.
REQ-035 memX_ren_o SHALL be 0 during reset regardless of input_request_i.

Verification
REQ-036 Single request id=2, block_cnt=9, addr1=4, addr2=5 -> memA_addr=22, memB_addr=23 same cycle; tile_valid_o at T+2 with tile_id_o=2, tile2_valid_o=1, tile_last_o=0.
REQ-037 Request addr1=8, addr2=8'hFF -> memB_ren_o=0; head tile2_o=0, tile2_valid_o=0, tile_last_o=1.
REQ-038 tile_ready_i=0, 6 back-to-back requests -> fifo_count_o reaches 4, 5th/6th dropped, overflow_o=1; first 4 pop in order; clear_i -> overflow_o=0.
REQ-039 FIFO full, tile_ready_i=1, continuous requests for 10 cycles -> no drop, count stays 4, overflow_o stays 0, 10 more tiles in order.
REQ-040 reset asserted in cycle after a request -> no tile ever appears, fifo_count_o=0.
REQ-041 id=15, block_cnt=255, addr1=255 -> memA_addr_o=4080.

Source files
------------

// File: rtl/data_controller.sv
// Tile fetch controller: issues dual-port block reads, pairs the returned tiles with
// their sideband and queues them in a small FIFO for a ready/valid consumer.
module data_controller #(
    parameter int DATA_W     = 128,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        input_addr_1_i,
    input  logic [7:0]        input_addr_2_i,
    input  logic              size_type_i,
    input  logic [7:0]        block_cnt_i,
    input  logic [3:0]        current_id_i,
    input  logic              input_request_i,
    output logic              memA_ren_o,
    output logic              memB_ren_o,
    output logic [11:0]       memA_addr_o,
    output logic [11:0]       memB_addr_o,
    input  logic [DATA_W-1:0] memA_rdata_i,
    input  logic [DATA_W-1:0] memB_rdata_i,
    output logic              tile_valid_o,
    input  logic              tile_ready_i,
    output logic [DATA_W-1:0] tile1_o,
    output logic [DATA_W-1:0] tile2_o,
    output logic              tile2_valid_o,
    output logic              tile_last_o,
    output logic              tile_size_type_o,
    output logic [3:0]        tile_id_o,
    output logic [2:0]        fifo_count_o,
    output logic              overflow_o,
    input  logic              clear_i
);

    localparam int         PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [2:0] FULL_CNT = 3'(FIFO_DEPTH);

    // Worst case 15*255+255 = 4080 fits in 12 bits, so the truncation never wraps.
    function automatic logic [11:0] block_addr(input logic [3:0] id,
                                               input logic [7:0] blk,
                                               input logic [7:0] addr);
        return 12'(id) * 12'(blk) + 12'(addr);
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic addr2_vld;

    assign addr2_vld   = (input_addr_2_i != 8'hFF);
    assign memA_addr_o = block_addr(current_id_i, block_cnt_i, input_addr_1_i);
    assign memB_addr_o = block_addr(current_id_i, block_cnt_i, input_addr_2_i);
    assign memA_ren_o  = input_request_i & ~reset;
    assign memB_ren_o  = input_request_i & addr2_vld & ~reset;

    // ---- stage 1: sideband waits one cycle for the read data ----
    logic       vld_p1;
    logic       t2v_p1;
    logic [3:0] id_p1;
    logic       size_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            t2v_p1  <= 1'b0;
            id_p1   <= '0;
            size_p1 <= 1'b0;
        end else begin
            vld_p1  <= input_request_i;
            t2v_p1  <= addr2_vld;
            id_p1   <= current_id_i;
            size_p1 <= size_type_i;
        end
    end

    // ---- FIFO control ----
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [2:0]       count;
    logic             empty;
    logic             full;
    logic             pop;
    logic             wr_en;
    logic             drop;

    assign empty = (count == 3'd0);
    assign full  = (count == FULL_CNT);
    assign pop   = ~empty & tile_ready_i;
    // A simultaneous pop frees the head slot, so a push into a full FIFO still lands.
    assign wr_en = vld_p1 & (~full | pop) & ~reset;
    assign drop  = vld_p1 & full & ~pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 3'd0;
        end else begin
            if (wr_en) wr_ptr <= next_ptr(wr_ptr);
            if (pop)   rd_ptr <= next_ptr(rd_ptr);
            case ({wr_en, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Set has priority over clear so a drop coinciding with clear_i is not lost.
    always_ff @(posedge clk) begin
        if (reset)        overflow_o <= 1'b0;
        else if (drop)    overflow_o <= 1'b1;
        else if (clear_i) overflow_o <= 1'b0;
    end

    // ---- FIFO storage: data path, not reset ----
    logic [DATA_W-1:0] t1_mem   [FIFO_DEPTH];
    logic [DATA_W-1:0] t2_mem   [FIFO_DEPTH];
    logic              t2v_mem  [FIFO_DEPTH];
    logic [3:0]        id_mem   [FIFO_DEPTH];
    logic              size_mem [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            t1_mem[wr_ptr]   <= memA_rdata_i;
            t2_mem[wr_ptr]   <= t2v_p1 ? memB_rdata_i : '0;
            t2v_mem[wr_ptr]  <= t2v_p1;
            id_mem[wr_ptr]   <= id_p1;
            size_mem[wr_ptr] <= size_p1;
        end
    end

    // ---- head outputs, forced to zero when nothing is queued ----
    assign tile_valid_o     = ~empty;
    assign tile1_o          = tile_valid_o ? t1_mem[rd_ptr] : '0;
    assign tile2_o          = tile_valid_o ? t2_mem[rd_ptr] : '0;
    assign tile2_valid_o    = tile_valid_o & t2v_mem[rd_ptr];
    assign tile_last_o      = tile_valid_o & ~t2v_mem[rd_ptr];
    assign tile_size_type_o = tile_valid_o & size_mem[rd_ptr];
    assign tile_id_o        = tile_valid_o ? id_mem[rd_ptr] : 4'd0;
    assign fifo_count_o     = count;

endmodule

// File: tb/tb_data_controller.sv
// Directed bench for data_controller with a behavioural one-cycle-latency memory.
module tb_data_controller;

    localparam int DATA_W = 128;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        input_addr_1_i, input_addr_2_i, block_cnt_i;
    logic              size_type_i, input_request_i, tile_ready_i, clear_i;
    logic [3:0]        current_id_i;
    logic              memA_ren_o, memB_ren_o;
    logic [11:0]       memA_addr_o, memB_addr_o;
    logic [DATA_W-1:0] memA_rdata_i, memB_rdata_i;
    logic              tile_valid_o, tile2_valid_o, tile_last_o, tile_size_type_o, overflow_o;
    logic [DATA_W-1:0] tile1_o, tile2_o;
    logic [3:0]        tile_id_o;
    logic [2:0]        fifo_count_o;

    int checks = 0;
    int errors = 0;

    data_controller #(.DATA_W(DATA_W), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .input_addr_1_i(input_addr_1_i), .input_addr_2_i(input_addr_2_i),
        .size_type_i(size_type_i), .block_cnt_i(block_cnt_i),
        .current_id_i(current_id_i), .input_request_i(input_request_i),
        .memA_ren_o(memA_ren_o), .memB_ren_o(memB_ren_o),
        .memA_addr_o(memA_addr_o), .memB_addr_o(memB_addr_o),
        .memA_rdata_i(memA_rdata_i), .memB_rdata_i(memB_rdata_i),
        .tile_valid_o(tile_valid_o), .tile_ready_i(tile_ready_i),
        .tile1_o(tile1_o), .tile2_o(tile2_o),
        .tile2_valid_o(tile2_valid_o), .tile_last_o(tile_last_o),
        .tile_size_type_o(tile_size_type_o), .tile_id_o(tile_id_o),
        .fifo_count_o(fifo_count_o), .overflow_o(overflow_o), .clear_i(clear_i)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] pat_a(input logic [11:0] a);
        return {8{4'hA, a}};
    endfunction

    function automatic logic [DATA_W-1:0] pat_b(input logic [11:0] a);
        return {8{4'hB, a}};
    endfunction

    // Memory model: data one cycle after ren; port B returns junk when not enabled.
    always @(posedge clk) begin
        memA_rdata_i <= memA_ren_o ? pat_a(memA_addr_o) : '0;
        memB_rdata_i <= memB_ren_o ? pat_b(memB_addr_o) : {4{32'hDEADBEEF}};
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        reset = 1'b1; input_request_i = 1'b1; input_addr_1_i = 8'd1; input_addr_2_i = 8'd2;
        block_cnt_i = 8'd0; current_id_i = 4'd0; size_type_i = 1'b0;
        tile_ready_i = 1'b0; clear_i = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (memA_ren_o !== 1'b0) begin errors++; $display("FAIL reset_renA: got %b want 0", memA_ren_o); end
        checks++; if (memB_ren_o !== 1'b0) begin errors++; $display("FAIL reset_renB: got %b want 0", memB_ren_o); end
        checks++; if (tile_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", tile_valid_o); end
        checks++; if (fifo_count_o !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow_o); end
        checks++; if (tile1_o !== '0 || tile_last_o !== 1'b0 || tile_id_o !== 4'd0) begin errors++; $display("FAIL reset_outputs: tile1 %0h last %b id %0d want 0", tile1_o, tile_last_o, tile_id_o); end
        input_request_i = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        current_id_i = 4'd2; block_cnt_i = 8'd9; input_addr_1_i = 8'd4; input_addr_2_i = 8'd5;
        size_type_i = 1'b0; input_request_i = 1'b1;
        #1;
        checks++; if (memA_addr_o !== 12'd22) begin errors++; $display("FAIL single_addrA: got %0d want 22", memA_addr_o); end
        checks++; if (memB_addr_o !== 12'd23) begin errors++; $display("FAIL single_addrB: got %0d want 23", memB_addr_o); end
        checks++; if (memA_ren_o !== 1'b1 || memB_ren_o !== 1'b1) begin errors++; $display("FAIL single_ren: got %b%b want 11", memA_ren_o, memB_ren_o); end
        @(negedge clk);
        input_request_i = 1'b0;
        checks++; if (tile_valid_o !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b want 0", tile_valid_o); end
        @(negedge clk);
        checks++; if (tile_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", tile_valid_o); end
        checks++; if (tile_id_o !== 4'd2) begin errors++; $display("FAIL single_id: got %0d want 2", tile_id_o); end
        checks++; if (tile2_valid_o !== 1'b1 || tile_last_o !== 1'b0) begin errors++; $display("FAIL single_side: t2v %b last %b want 1 0", tile2_valid_o, tile_last_o); end
        checks++; if (tile1_o !== pat_a(12'd22)) begin errors++; $display("FAIL single_tile1: got %0h want %0h", tile1_o, pat_a(12'd22)); end
        checks++; if (tile2_o !== pat_b(12'd23)) begin errors++; $display("FAIL single_tile2: got %0h want %0h", tile2_o, pat_b(12'd23)); end
        checks++; if (fifo_count_o !== 3'd1) begin errors++; $display("FAIL single_count: got %0d want 1", fifo_count_o); end
        tile_ready_i = 1'b1;
        @(negedge clk);
        tile_ready_i = 1'b0;
        checks++; if (tile_valid_o !== 1'b0 || fifo_count_o !== 3'd0) begin errors++; $display("FAIL single_pop: valid %b count %0d want 0 0", tile_valid_o, fifo_count_o); end
        checks++; if (tile1_o !== '0 || tile2_o !== '0 || tile_id_o !== 4'd0) begin errors++; $display("FAIL single_zero: tile1 %0h tile2 %0h id %0d want 0", tile1_o, tile2_o, tile_id_o); end
    endtask

    task automatic test_no_second();
        current_id_i = 4'd0; block_cnt_i = 8'd0; input_addr_1_i = 8'd8; input_addr_2_i = 8'hFF;
        size_type_i = 1'b1; input_request_i = 1'b1;
        #1;
        checks++; if (memB_ren_o !== 1'b0 || memA_ren_o !== 1'b1) begin errors++; $display("FAIL nosec_ren: got %b%b want 10", memA_ren_o, memB_ren_o); end
        @(negedge clk);
        input_request_i = 1'b0;
        @(negedge clk);
        checks++; if (tile_valid_o !== 1'b1 || tile1_o !== pat_a(12'd8)) begin errors++; $display("FAIL nosec_tile1: valid %b tile1 %0h want 1 %0h", tile_valid_o, tile1_o, pat_a(12'd8)); end
        checks++; if (tile2_o !== '0) begin errors++; $display("FAIL nosec_tile2: got %0h want 0", tile2_o); end
        checks++; if (tile2_valid_o !== 1'b0 || tile_last_o !== 1'b1 || tile_size_type_o !== 1'b1) begin errors++; $display("FAIL nosec_side: t2v %b last %b size %b want 0 1 1", tile2_valid_o, tile_last_o, tile_size_type_o); end
        @(negedge clk);
        checks++; if (tile1_o !== pat_a(12'd8) || fifo_count_o !== 3'd1) begin errors++; $display("FAIL nosec_hold: tile1 %0h count %0d want %0h 1", tile1_o, fifo_count_o, pat_a(12'd8)); end
        tile_ready_i = 1'b1;
        @(negedge clk);
        tile_ready_i = 1'b0;
        checks++; if (fifo_count_o !== 3'd0) begin errors++; $display("FAIL nosec_pop: count %0d want 0", fifo_count_o); end
    endtask

    task automatic test_overflow();
        current_id_i = 4'd0; block_cnt_i = 8'd0; input_addr_2_i = 8'hFF; size_type_i = 1'b0;
        tile_ready_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            input_request_i = 1'b1; input_addr_1_i = 8'(k);
            @(negedge clk);
        end
        input_request_i = 1'b0;
        checks++; if (fifo_count_o !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d want 4", fifo_count_o); end
        checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow_o); end
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        checks++; if (overflow_o !== 1'b1 || fifo_count_o !== 3'd4) begin errors++; $display("FAIL ovf_clear_prio: ovf %b count %0d want 1 4", overflow_o, fifo_count_o); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (tile_valid_o !== 1'b1 || tile1_o !== pat_a(12'(k))) begin errors++; $display("FAIL ovf_order%0d: valid %b tile1 %0h want 1 %0h", k, tile_valid_o, tile1_o, pat_a(12'(k))); end
            tile_ready_i = 1'b1;
            @(negedge clk);
        end
        tile_ready_i = 1'b0;
        checks++; if (fifo_count_o !== 3'd0 || tile_valid_o !== 1'b0 || overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_drained: count %0d valid %b ovf %b want 0 0 1", fifo_count_o, tile_valid_o, overflow_o); end
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", overflow_o); end
    endtask

    task automatic test_back_to_back();
        int exp_addr [14];
        for (int i = 0; i < 4; i++) exp_addr[i] = i;
        for (int i = 4; i < 14; i++) exp_addr[i] = i + 6;
        current_id_i = 4'd0; block_cnt_i = 8'd0; input_addr_2_i = 8'hFF;
        for (int c = 0; c < 20; c++) begin
            if (c >= 5 && c <= 18) begin
                checks++; if (tile_valid_o !== 1'b1 || tile1_o !== pat_a(12'(exp_addr[c-5]))) begin errors++; $display("FAIL b2b_head%0d: valid %b tile1 %0h want 1 %0h", c, tile_valid_o, tile1_o, pat_a(12'(exp_addr[c-5]))); end
            end
            if (c >= 6 && c <= 15) begin
                checks++; if (fifo_count_o !== 3'd4 || overflow_o !== 1'b0) begin errors++; $display("FAIL b2b_count%0d: count %0d ovf %b want 4 0", c, fifo_count_o, overflow_o); end
            end
            input_request_i = (c <= 13);
            input_addr_1_i  = 8'((c < 4) ? c : c + 6);
            tile_ready_i    = (c >= 5);
            @(negedge clk);
        end
        input_request_i = 1'b0; tile_ready_i = 1'b0;
        checks++; if (fifo_count_o !== 3'd0 || overflow_o !== 1'b0) begin errors++; $display("FAIL b2b_end: count %0d ovf %b want 0 0", fifo_count_o, overflow_o); end
    endtask

    task automatic test_reset_inflight();
        input_addr_1_i = 8'd3; input_addr_2_i = 8'd4; input_request_i = 1'b1;
        @(negedge clk);
        input_request_i = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (tile_valid_o !== 1'b0 || fifo_count_o !== 3'd0) begin errors++; $display("FAIL inflight%0d: valid %b count %0d want 0 0", i, tile_valid_o, fifo_count_o); end
            @(negedge clk);
        end
    endtask

    task automatic test_max_addr();
        current_id_i = 4'd15; block_cnt_i = 8'd255; input_addr_1_i = 8'd255; input_addr_2_i = 8'd0;
        input_request_i = 1'b0;
        #1;
        checks++; if (memA_addr_o !== 12'd4080) begin errors++; $display("FAIL max_addrA: got %0d want 4080", memA_addr_o); end
        checks++; if (memB_addr_o !== 12'd3825) begin errors++; $display("FAIL max_addrB: got %0d want 3825", memB_addr_o); end
        checks++; if (memA_ren_o !== 1'b0) begin errors++; $display("FAIL max_ren: got %b want 0", memA_ren_o); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_no_second();
        test_overflow();
        test_back_to_back();
        test_reset_inflight();
        test_max_addr();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
